cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 15 +
 rtl/cdb_arbiter_rr_priority_picker.sv | 31 +++
 rtl/cdb_arbiter.sv | 94 +++++++++
 tb/tb_cdb_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared constants for the common data bus arbiter
package cdb_arbiter_pkg;

  localparam int TAG_W   = 3;
  localparam int RDEST_W = 3;

  localparam logic [TAG_W-1:0] FREE = 3'd0;
  localparam logic [TAG_W-1:0] ADD1 = 3'd1;
  localparam logic [TAG_W-1:0] ADD2 = 3'd2;
  localparam logic [TAG_W-1:0] MUL1 = 3'd3;
  localparam logic [TAG_W-1:0] MUL2 = 3'd4;

  localparam logic [15:0] NO_VALUE = 16'hFFF0;

endpackage

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// rtl/cdb_arbiter_rr_priority_picker.sv - combinational round-robin winner search
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] winner_o,
  output logic             found_o
);

  logic [IDX_W:0] cand;

  // Walk indices last+1, last+2, ... wrapping at N_REQ; first eligible one wins.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_i} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found_o && eligible_i[cand[IDX_W-1:0]]) begin
        winner_o[cand[IDX_W-1:0]] = 1'b1;
        found_o                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int                N_REQ    = 4,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] NO_VALUE = DATA_W'(cdb_arbiter_pkg::NO_VALUE)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [N_REQ-1:0]          Req,
  input  logic [N_REQ*DATA_W-1:0]   Req_Data,
  input  logic [N_REQ*RDEST_W-1:0]  Req_Rdest,
  input  logic                      Hold,
  output logic [N_REQ-1:0]          Grant,
  output logic                      CDB_Valid,
  output logic [TAG_W-1:0]          CDB_Tag,
  output logic [DATA_W-1:0]         CDB_Data,
  output logic [RDEST_W-1:0]        CDB_Rdest
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [RDEST_W-1:0] rdest_q, rdest_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   winner;
  logic               found;

  // A unit still holding Req during its Grant cycle must not win again.
  assign eligible = Req & ~grant_q;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .eligible_i (eligible),
    .last_i     (last_q),
    .winner_o   (winner),
    .found_o    (found)
  );

  always_comb begin
    grant_d = '0;
    valid_d = 1'b0;
    tag_d   = FREE;
    data_d  = NO_VALUE;
    rdest_d = '0;
    last_d  = last_q;
    if (found && !Hold) begin
      grant_d = winner;
      valid_d = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (winner[i]) begin
          tag_d   = TAG_W'(i + 1);
          data_d  = Req_Data[i*DATA_W +: DATA_W];
          rdest_d = Req_Rdest[i*RDEST_W +: RDEST_W];
          last_d  = IDX_W'(i);
        end
      end
    end
  end

  // Last resets to the top index so index 0 is searched first.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      tag_q   <= FREE;
      data_q  <= NO_VALUE;
      rdest_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      rdest_q <= rdest_d;
      last_q  <= last_d;
    end
  end

  assign Grant     = grant_q;
  assign CDB_Valid = valid_q;
  assign CDB_Tag   = tag_q;
  assign CDB_Data  = data_q;
  assign CDB_Rdest = rdest_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  logic        Clock;
  logic        Reset;
  logic [3:0]  Req;
  logic [63:0] Req_Data;
  logic [11:0] Req_Rdest;
  logic        Hold;
  logic [3:0]  Grant;
  logic        CDB_Valid;
  logic [2:0]  CDB_Tag;
  logic [15:0] CDB_Data;
  logic [2:0]  CDB_Rdest;

  int tests;
  int fails;
  int pulses;

  cdb_arbiter dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req       (Req),
    .Req_Data  (Req_Data),
    .Req_Rdest (Req_Rdest),
    .Hold      (Hold),
    .Grant     (Grant),
    .CDB_Valid (CDB_Valid),
    .CDB_Tag   (CDB_Tag),
    .CDB_Data  (CDB_Data),
    .CDB_Rdest (CDB_Rdest)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic v,
                         input logic [2:0] t, input logic [15:0] d, input logic [2:0] r);
    check({tag, ".grant"}, 32'(Grant), 32'(g));
    check({tag, ".valid"}, 32'(CDB_Valid), 32'(v));
    check({tag, ".tag"},   32'(CDB_Tag), 32'(t));
    check({tag, ".data"},  32'(CDB_Data), 32'(d));
    check({tag, ".rdest"}, 32'(CDB_Rdest), 32'(r));
  endtask

  task automatic idle_chk(input string tag);
    chk_out(tag, 4'b0000, 1'b0, 3'd0, 16'hFFF0, 3'd0);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_unit(input int i, input logic [15:0] d, input logic [2:0] r);
    Req[i]             = 1'b1;
    Req_Data[i*16 +: 16] = d;
    Req_Rdest[i*3 +: 3]  = r;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    pulses    = 0;
    Reset     = 1'b1;
    Req       = '0;
    Req_Data  = '0;
    Req_Rdest = '0;
    Hold      = 1'b0;

    #2;
    idle_chk("reset");
    step();
    idle_chk("reset_clk");
    Reset = 1'b0;
    step();
    idle_chk("post_reset_idle");

    // All four request; each drops after its grant -> tags 1,2,3,4
    for (int i = 0; i < 4; i++) set_unit(i, 16'h1000 + 16'(i), 3'(i + 4));
    step(); chk_out("rr_t1", 4'b0001, 1'b1, 3'd1, 16'h1000, 3'd4); Req[0] = 1'b0;
    step(); chk_out("rr_t2", 4'b0010, 1'b1, 3'd2, 16'h1001, 3'd5); Req[1] = 1'b0;
    step(); chk_out("rr_t3", 4'b0100, 1'b1, 3'd3, 16'h1002, 3'd6); Req[2] = 1'b0;
    step(); chk_out("rr_t4", 4'b1000, 1'b1, 3'd4, 16'h1003, 3'd7); Req[3] = 1'b0;
    step(); idle_chk("rr_idle");

    // Single request
    set_unit(0, 16'h0005, 3'd3);
    step(); chk_out("single", 4'b0001, 1'b1, 3'd1, 16'h0005, 3'd3); Req[0] = 1'b0;
    step(); idle_chk("single_after");

    // Set Last=3, then Req=1001 wraps to tag 1 before tag 4
    set_unit(3, 16'h00A3, 3'd1);
    step(); chk_out("wrap_pre", 4'b1000, 1'b1, 3'd4, 16'h00A3, 3'd1); Req[3] = 1'b0;
    step(); idle_chk("wrap_pre_idle");
    set_unit(0, 16'h00B0, 3'd2);
    set_unit(3, 16'h00B3, 3'd5);
    step(); chk_out("wrap_t1", 4'b0001, 1'b1, 3'd1, 16'h00B0, 3'd2); Req[0] = 1'b0;
    step(); chk_out("wrap_t4", 4'b1000, 1'b1, 3'd4, 16'h00B3, 3'd5); Req[3] = 1'b0;
    step(); idle_chk("wrap_idle");

    // Hold for three edges, then tags 2 and 3 back-to-back
    Hold = 1'b1;
    set_unit(1, 16'h2222, 3'd2);
    set_unit(2, 16'h3333, 3'd3);
    for (int c = 0; c < 3; c++) begin
      step(); idle_chk($sformatf("hold_%0d", c));
    end
    Hold = 1'b0;
    step(); chk_out("hold_t2", 4'b0010, 1'b1, 3'd2, 16'h2222, 3'd2); Req[1] = 1'b0;
    step(); chk_out("hold_t3", 4'b0100, 1'b1, 3'd3, 16'h3333, 3'd3); Req[2] = 1'b0;
    step(); idle_chk("hold_idle");

    // Req stays high through its Grant cycle -> only one pulse
    set_unit(0, 16'h0D0D, 3'd6);
    for (int c = 0; c < 3; c++) begin
      step();
      if (Grant[0]) pulses++;
      if (c == 1) Req[0] = 1'b0;
    end
    check("nodbl_pulses", 32'(pulses), 32'd1);
    idle_chk("nodbl_idle");

    // Reset while a broadcast is valid
    set_unit(1, 16'hABCD, 3'd2);
    step(); chk_out("rst_pre", 4'b0010, 1'b1, 3'd2, 16'hABCD, 3'd2);
    Req[1] = 1'b0;
    Reset  = 1'b1;
    #1;
    idle_chk("rst_async");
    step();
    Reset = 1'b0;
    idle_chk("rst_release");
    set_unit(2, 16'h0777, 3'd6);
    step(); chk_out("rst_t3", 4'b0100, 1'b1, 3'd3, 16'h0777, 3'd6); Req[2] = 1'b0;
    step(); idle_chk("rst_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
